// File: rtl/lane_hit_arbiter.sv
// Round-robin arbiter serialising per-lane press pulses into a buffered hit-event stream.
// Optional per-lane lockout after each grant is compiled in with `define LANE_LOCKOUT_EN.
module lane_hit_arbiter #(
  parameter int LANES   = 4,
  parameter int DEPTH   = 4,
  parameter int LOCKOUT = 800000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 mode,
  input  logic [LANES-1:0]           press,
  output logic                       hit_valid,
  output logic [$clog2(LANES)-1:0]   hit_lane,
  input  logic                       hit_ready,
  output logic [7:0]                 drop_count,
  output logic                       busy
);

  localparam int LW   = $clog2(LANES);
  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic             play;
  logic [LANES-1:0] pend_q, pend_d;
  logic [LANES-1:0] grant;
  logic [LANES-1:0] locked;
  logic [LANES-1:0] accept;
  logic [LW-1:0]    last_q, last_d;
  logic [LW-1:0]    grant_lane;
  logic [LW-1:0]    cand;
  logic             push, pop;
  logic [LW-1:0]    mem_q [DEPTH];
  logic [PW-1:0]    rd_q, wr_q;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [7:0]       drop_q, drop_d;
  logic [8:0]       drop_sum;

  assign play = (mode == 3'd4);

  // Search starts one past the last winner so every lane gets a turn.
  always_comb begin
    push       = 1'b0;
    grant_lane = last_q;
    cand       = '0;
    if (play && (cnt_q < CNTW'(DEPTH))) begin
      for (int k = 1; k <= LANES; k++) begin
        cand = LW'((int'(last_q) + k) % LANES);
        if (!push && pend_q[cand]) begin
          push       = 1'b1;
          grant_lane = cand;
        end
      end
    end
    grant = push ? (LANES'(1) << grant_lane) : '0;
  end

  assign last_d = push ? grant_lane : last_q;

  // A press on a lane that is pending (including the one being granted) is a drop.
  always_comb begin
    accept   = '0;
    drop_sum = {1'b0, drop_q};
    if (play) begin
      for (int i = 0; i < LANES; i++) begin
        if (press[i]) begin
          if (pend_q[i]) begin
            drop_sum = drop_sum + 9'd1;
          end else if (!locked[i]) begin
            accept[i] = 1'b1;
          end
        end
      end
    end
    drop_d = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
    pend_d = play ? ((pend_q & ~grant) | accept) : '0;
  end

  assign hit_valid = (cnt_q != '0);
  assign pop       = hit_valid && hit_ready;
  assign cnt_d     = cnt_q + CNTW'(push) - CNTW'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      last_q <= LW'(LANES - 1);
      drop_q <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      for (int d = 0; d < DEPTH; d++) mem_q[d] <= '0;
    end else begin
      pend_q <= pend_d;
      last_q <= last_d;
      drop_q <= drop_d;
      if (!play) begin
        rd_q  <= '0;
        wr_q  <= '0;
        cnt_q <= '0;
      end else begin
        if (push) begin
          mem_q[wr_q] <= grant_lane;
          wr_q        <= wr_q + PW'(1);
        end
        if (pop) rd_q <= rd_q + PW'(1);
        cnt_q <= cnt_d;
      end
    end
  end

`ifdef LANE_LOCKOUT_EN
  localparam int LCW = $clog2(LOCKOUT + 1);

  logic [LCW-1:0] lock_q [LANES];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (rst || !play) begin
        lock_q[i] <= '0;
      end else if (grant[i]) begin
        lock_q[i] <= LCW'(LOCKOUT);
      end else if (lock_q[i] != '0) begin
        lock_q[i] <= lock_q[i] - LCW'(1);
      end
    end
  end

  always_comb begin
    locked = '0;
    for (int i = 0; i < LANES; i++) locked[i] = (lock_q[i] != '0);
  end
`else
  // Without lockout the LOCKOUT parameter has no role.
  logic lockout_unused;
  assign lockout_unused = (LOCKOUT != 0);
  assign locked         = '0;
`endif

  assign hit_lane   = mem_q[rd_q];
  assign drop_count = drop_q;
  assign busy       = (|pend_q) || (cnt_q != '0);

endmodule

// File: tb/tb_lane_hit_arbiter.sv
// Scoreboard bench for lane_hit_arbiter: directed scenarios plus randomized traffic against a reference model.
module tb_lane_hit_arbiter;
  localparam int LANES   = 4;
  localparam int DEPTH   = 4;
  localparam int LOCKOUT = 4;
`ifdef LANE_LOCKOUT_EN
  localparam int LOCK_M = LOCKOUT;
`else
  localparam int LOCK_M = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] mode;
  logic [3:0] press;
  logic       hit_valid;
  logic [1:0] hit_lane;
  logic       hit_ready;
  logic [7:0] drop_count;
  logic       busy;

  always #5 clk = ~clk;

  lane_hit_arbiter #(.LANES(LANES), .DEPTH(DEPTH), .LOCKOUT(LOCKOUT)) dut (
    .clk(clk), .rst(rst), .mode(mode), .press(press),
    .hit_valid(hit_valid), .hit_lane(hit_lane), .hit_ready(hit_ready),
    .drop_count(drop_count), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model state
  bit m_pend[LANES];
  int m_lock[LANES];
  int m_last  = LANES - 1;
  int m_cnt   = 0;
  int m_drops = 0;
  int exp_q[$];
  int seen[$];
  bit mon_en = 0;

  always @(posedge clk) begin : model
    int g, j, popn;
    bit acc[LANES];
    if (rst) begin
      for (int i = 0; i < LANES; i++) begin m_pend[i] = 0; m_lock[i] = 0; end
      m_last = LANES - 1; m_cnt = 0; m_drops = 0;
      exp_q.delete();
    end else if (mode != 3'd4) begin
      for (int i = 0; i < LANES; i++) begin m_pend[i] = 0; m_lock[i] = 0; end
      m_cnt = 0;
      exp_q.delete();
    end else begin
      g = -1;
      popn = (m_cnt > 0 && hit_ready) ? 1 : 0;
      if (m_cnt < DEPTH)
        for (int k = 1; k <= LANES; k++) begin
          j = (m_last + k) % LANES;
          if (g < 0 && m_pend[j]) g = j;
        end
      for (int i = 0; i < LANES; i++) begin
        acc[i] = 0;
        if (press[i]) begin
          if (m_pend[i]) m_drops = (m_drops < 255) ? m_drops + 1 : 255;
          else if (m_lock[i] == 0) acc[i] = 1;
        end
        if (m_lock[i] > 0) m_lock[i]--;
      end
      if (g >= 0) begin
        m_lock[g] = LOCK_M;
        m_pend[g] = 0;
        m_last    = g;
        exp_q.push_back(g);
      end
      for (int i = 0; i < LANES; i++) if (acc[i]) m_pend[i] = 1;
      m_cnt = m_cnt + ((g >= 0) ? 1 : 0) - popn;
    end
  end

  always @(negedge clk) begin : monitor
    bit anyp;
    int e;
    if (mon_en && !rst) begin
      anyp = 0;
      for (int i = 0; i < LANES; i++) anyp |= m_pend[i];
      chk("hit_valid", hit_valid, (m_cnt > 0) ? 1 : 0);
      chk("busy", busy, (anyp || m_cnt > 0) ? 1 : 0);
      chk("drop_count", drop_count, m_drops);
      if (hit_valid && hit_ready) begin
        chk("hit_has_expected", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("hit_lane", hit_lane, e);
        end
        seen.push_back(int'(hit_lane));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tap(input logic [3:0] p);
    press = p;
    cyc(1);
    press = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    seen.delete();
  endtask

  initial begin
    rst = 1'b1; mode = 3'd4; press = '0; hit_ready = 1'b1;
    #1;
    cyc(2);
    rst = 1'b0;
    mon_en = 1'b1;
    chk("reset_hit_valid", hit_valid, 0);
    chk("reset_hit_lane", hit_lane, 0);
    chk("reset_drop_count", drop_count, 0);
    chk("reset_busy", busy, 0);

    // Single press: event two cycles later, idle one cycle after that
    tap(4'b0100);
    cyc(1);
    chk("single_valid_t2", hit_valid, 1);
    chk("single_lane_t2", hit_lane, 2);
    cyc(1);
    chk("single_busy_t3", busy, 0);
    chk("single_valid_t3", hit_valid, 0);
    cyc(6);

    // Chord after reset, then repeated once lockout has expired
    do_reset();
    tap(4'b1011);
    cyc(5);
    chk("chord1_n", seen.size(), 3);
    chk("chord1_0", seen[0], 0); chk("chord1_1", seen[1], 1); chk("chord1_2", seen[2], 3);
    cyc(4);
    seen.delete();
    tap(4'b1011);
    cyc(5);
    chk("chord2_n", seen.size(), 3);
    chk("chord2_0", seen[0], 0); chk("chord2_1", seen[1], 1); chk("chord2_2", seen[2], 3);

    // Backpressure and drops on a full FIFO
    do_reset();
    hit_ready = 1'b0;
    tap(4'b1111);
    cyc(6);
    chk("bp_full_valid", hit_valid, 1);
    chk("bp_head", hit_lane, 0);
    tap(4'b0001);
    cyc(2);
    chk("bp_held_busy", busy, 1);
    tap(4'b0010);
    repeat (3) tap(4'b0010);
    chk("drop3", drop_count, 3);
    hit_ready = 1'b1;
    cyc(10);
    chk("drain_n", seen.size(), 6);
    chk("drain_0", seen[0], 0); chk("drain_1", seen[1], 1); chk("drain_2", seen[2], 2);
    chk("drain_3", seen[3], 3); chk("drain_4", seen[4], 0); chk("drain_5", seen[5], 1);

    // Saturation of the drop counter
    do_reset();
    hit_ready = 1'b0;
    tap(4'b1111);
    cyc(8);
    tap(4'b0010);
    cyc(1);
    repeat (300) begin
      tap(4'b0010);
      cyc(1);
    end
    chk("drop_sat", drop_count, 255);

    // Lockout window
    do_reset();
    hit_ready = 1'b1;
    tap(4'b0001);
`ifdef LANE_LOCKOUT_EN
    cyc(1);
    repeat (4) tap(4'b0001);
    tap(4'b0001);
`else
    cyc(2);
    tap(4'b0001);
`endif
    cyc(6);
    chk("lockout_events", seen.size(), 2);
    chk("lockout_drops", drop_count, 0);

    // Leaving play mode flushes everything
    do_reset();
    hit_ready = 1'b0;
    press = 4'b0011; cyc(1);
    press = '0;      cyc(1);
    press = 4'b1000; cyc(1);
    press = '0;
    chk("modex_before_valid", hit_valid, 1);
    mode = 3'd3;
    cyc(1);
    chk("modex_valid", hit_valid, 0);
    chk("modex_busy", busy, 0);
    press = 4'b1111; cyc(3);
    press = '0; hit_ready = 1'b1; cyc(3);
    chk("modex_no_events", seen.size(), 0);
    mode = 3'd4;
    tap(4'b0100);
    cyc(4);
    chk("mode_entry_n", seen.size(), 1);
    chk("mode_entry_lane", seen[0], 2);

    // Randomized traffic
    do_reset();
    repeat (3000) begin
      press     = 4'($urandom) & 4'($urandom);
      hit_ready = ($urandom_range(0, 3) != 0);
      mode      = ($urandom_range(0, 99) == 0) ? 3'($urandom_range(0, 3)) : 3'd4;
      rst       = ($urandom_range(0, 299) == 0);
      cyc(1);
    end
    rst = 1'b0; mode = 3'd4; press = '0; hit_ready = 1'b1;
    cyc(12);
    chk("final_scoreboard_empty", exp_q.size(), 0);
    chk("final_busy", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
